// File: rtl/bldc_commutator_pkg.sv
// bldc_commutator_pkg: state encodings, hall-code constants, phase select codes and the commutation table
package bldc_commutator_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_COAST, ST_FAULT} state_t;

    typedef enum logic [1:0] {SEL_FLOAT, SEL_HIGH, SEL_LOW} phase_sel_t;

    typedef struct packed {
        phase_sel_t c;
        phase_sel_t b;
        phase_sel_t a;
    } comm_row_t;

    localparam logic [2:0] HALL_ALL_LOW  = 3'b000;
    localparam logic [2:0] HALL_ALL_HIGH = 3'b111;

    localparam logic [1:0] PH_A    = 2'd0;
    localparam logic [1:0] PH_B    = 2'd1;
    localparam logic [1:0] PH_C    = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    function automatic logic hall_valid(input logic [2:0] code);
        return code != HALL_ALL_LOW && code != HALL_ALL_HIGH;
    endfunction

    function automatic phase_sel_t sel_for(input logic [1:0] ph, input logic [1:0] hi, input logic [1:0] lo);
        return ph == hi ? SEL_HIGH : ph == lo ? SEL_LOW : SEL_FLOAT;
    endfunction

    // Forward rows; reverse swaps the high and low phase of the same row
    function automatic comm_row_t comm_row(input logic [2:0] code, input logic fwd);
        logic [1:0] hi, lo;
        comm_row_t r;
        case (code)
            3'd1:    {hi, lo} = {PH_A, PH_B};
            3'd3:    {hi, lo} = {PH_A, PH_C};
            3'd2:    {hi, lo} = {PH_B, PH_C};
            3'd6:    {hi, lo} = {PH_B, PH_A};
            3'd4:    {hi, lo} = {PH_C, PH_A};
            3'd5:    {hi, lo} = {PH_C, PH_B};
            default: {hi, lo} = {PH_NONE, PH_NONE};
        endcase
        {hi, lo} = fwd ? {hi, lo} : {lo, hi};
        r.a = sel_for(PH_A, hi, lo);
        r.b = sel_for(PH_B, hi, lo);
        r.c = sel_for(PH_C, hi, lo);
        return r;
    endfunction

endpackage

// File: rtl/bldc_commutator_if.sv
// bldc_commutator_if: motor command inputs, raw halls and phase-driver/status outputs
interface bldc_commutator_if #(parameter int DUTY_WIDTH = 10);

    logic                  enable;
    logic                  direction;
    logic                  brake;
    logic [DUTY_WIDTH-1:0] duty_cmd;
    logic [2:0]            hall;
    logic [DUTY_WIDTH-1:0] duty_a;
    logic [DUTY_WIDTH-1:0] duty_b;
    logic [DUTY_WIDTH-1:0] duty_c;
    logic                  high_z_a;
    logic                  high_z_b;
    logic                  high_z_c;
    logic                  hall_fault;
    logic                  stall_fault;
    logic [15:0]           comm_count;

    modport master (
        output enable, direction, brake, duty_cmd, hall,
        input  duty_a, duty_b, duty_c, high_z_a, high_z_b, high_z_c,
               hall_fault, stall_fault, comm_count
    );

    modport slave (
        input  enable, direction, brake, duty_cmd, hall,
        output duty_a, duty_b, duty_c, high_z_a, high_z_b, high_z_c,
               hall_fault, stall_fault, comm_count
    );

endinterface

// File: rtl/bldc_commutator_hall_filter.sv
// bldc_commutator_hall_filter: 2-FF hall synchronizer plus debounce; emits accepted code and a change strobe
module bldc_commutator_hall_filter #(
    parameter int HALL_FILTER = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] hall,
    output logic [2:0] code,
    output logic       accept
);

    localparam int CW = $clog2(HALL_FILTER + 1);

    logic [2:0]    sync1, sync2, cand;
    logic [CW-1:0] cnt;
    logic          take;

    assign take = cnt == CW'(HALL_FILTER) && cand != code;

    // two-flop synchronizer for the asynchronous hall lines
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= hall;
            sync2 <= sync1;
        end
    end

    // track the run length of the current sample and publish it once it has held long enough
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand   <= '0;
            cnt    <= '0;
            code   <= '0;
            accept <= 1'b0;
        end else begin
            cand   <= sync2;
            cnt    <= sync2 != cand ? CW'(1) : cnt == CW'(HALL_FILTER) ? cnt : cnt + 1'b1;
            code   <= take ? cand : code;
            accept <= take;
        end
    end

endmodule

// File: rtl/bldc_commutator.sv
// bldc_commutator: six-step BLDC commutation sequencer; DUTY_SLEW_EN adds a duty slew limiter
module bldc_commutator
    import bldc_commutator_pkg::*;
#(
    parameter int DUTY_WIDTH   = 10,
    parameter int HALL_FILTER  = 16,
    parameter int STALL_CYCLES = 2**20,
    parameter int COAST_CYCLES = 1024
`ifdef DUTY_SLEW_EN
    ,
    parameter int SLEW_DIV     = 256,
    parameter int SLEW_STEP    = 1
`endif
) (
    input logic              clock,
    input logic              reset_n,
    bldc_commutator_if.slave bus
);

    localparam int SW  = $clog2(STALL_CYCLES + 1);
    localparam int CCW = $clog2(COAST_CYCLES + 1);

    state_t                state, state_nxt;
    logic [2:0]            code;
    logic                  accept;
    logic                  dir_q, toggle;
    logic [SW-1:0]         stall_cnt;
    logic                  stall_hit;
    logic [CCW-1:0]        coast_cnt;
    logic                  coast_done;
    logic [DUTY_WIDTH-1:0] duty_app;
    logic                  set_hall, set_stall;
    comm_row_t             row;
    logic                  run, drive;
    logic [DUTY_WIDTH-1:0] da_n, db_n, dc_n;
    logic [2:0]            hz_n;

    bldc_commutator_hall_filter #(.HALL_FILTER(HALL_FILTER)) u_hall_filter (
        .clock  (clock),
        .reset_n(reset_n),
        .hall   (bus.hall),
        .code   (code),
        .accept (accept)
    );

    assign toggle     = bus.direction != dir_q;
    assign stall_hit  = stall_cnt == SW'(STALL_CYCLES);
    assign coast_done = coast_cnt == CCW'(COAST_CYCLES - 1);

    // sequencer next state; enable=0 wins, then faults, then direction reversal
    always_comb begin
        state_nxt = state;
        set_hall  = 1'b0;
        set_stall = 1'b0;
        if (!bus.enable)
            state_nxt = ST_IDLE;
        else
            case (state)
                ST_IDLE: begin
                    state_nxt = hall_valid(code) ? ST_RUN : ST_FAULT;
                    set_hall  = !hall_valid(code);
                end
                ST_RUN: begin
                    set_hall  = !hall_valid(code);
                    set_stall = hall_valid(code) && stall_hit;
                    state_nxt = set_hall || set_stall ? ST_FAULT : toggle ? ST_COAST : ST_RUN;
                end
                ST_COAST: begin
                    set_hall  = !hall_valid(code);
                    state_nxt = set_hall ? ST_FAULT : coast_done ? ST_RUN : ST_COAST;
                end
                default: state_nxt = ST_FAULT;
            endcase
    end

    // state, timers, latched faults and commutation counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            dir_q           <= 1'b0;
            stall_cnt       <= '0;
            coast_cnt       <= '0;
            bus.hall_fault  <= 1'b0;
            bus.stall_fault <= 1'b0;
            bus.comm_count  <= '0;
        end else begin
            state           <= state_nxt;
            dir_q           <= bus.direction;
            stall_cnt       <= state != ST_RUN || accept || duty_app == '0 || bus.brake ? '0 :
                               stall_hit ? stall_cnt : stall_cnt + 1'b1;
            coast_cnt       <= state == ST_COAST ? coast_cnt + 1'b1 : '0;
            bus.hall_fault  <= bus.enable && (bus.hall_fault || set_hall);
            bus.stall_fault <= bus.enable && (bus.stall_fault || set_stall);
            bus.comm_count  <= accept && (state == ST_RUN || state == ST_COAST) ? bus.comm_count + 1'b1 : bus.comm_count;
        end
    end

`ifdef DUTY_SLEW_EN
    localparam int DIVW = $clog2(SLEW_DIV + 1);

    logic [DIVW-1:0]       div_cnt;
    logic [DUTY_WIDTH-1:0] step, up_gap, dn_gap, slew_nxt;

    assign step     = DUTY_WIDTH'(SLEW_STEP);
    assign up_gap   = bus.duty_cmd - duty_app;
    assign dn_gap   = duty_app - bus.duty_cmd;
    assign slew_nxt = bus.duty_cmd > duty_app ? (up_gap > step ? duty_app + step : bus.duty_cmd) :
                                                (dn_gap > step ? duty_app - step : bus.duty_cmd);

    // applied duty ramps toward the command in RUN and is held at zero elsewhere
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            duty_app <= '0;
        end else if (state != ST_RUN) begin
            div_cnt  <= '0;
            duty_app <= '0;
        end else begin
            div_cnt  <= div_cnt == DIVW'(SLEW_DIV - 1) ? '0 : div_cnt + 1'b1;
            duty_app <= div_cnt == DIVW'(SLEW_DIV - 1) ? slew_nxt : duty_app;
        end
    end
`else
    // applied duty is the command delayed by one clock
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            duty_app <= '0;
        else
            duty_app <= bus.duty_cmd;
    end
`endif

    // phase drive for the state being entered, so drive and state change on the same edge
    always_comb begin
        row   = comm_row(code, bus.direction);
        run   = state_nxt == ST_RUN;
        drive = run && !bus.brake;
        da_n  = drive && row.a == SEL_HIGH ? duty_app : '0;
        db_n  = drive && row.b == SEL_HIGH ? duty_app : '0;
        dc_n  = drive && row.c == SEL_HIGH ? duty_app : '0;
        hz_n  = {!run || (drive && row.c == SEL_FLOAT),
                 !run || (drive && row.b == SEL_FLOAT),
                 !run || (drive && row.a == SEL_FLOAT)};
    end

    // registered phase-driver outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.duty_a   <= '0;
            bus.duty_b   <= '0;
            bus.duty_c   <= '0;
            bus.high_z_a <= 1'b1;
            bus.high_z_b <= 1'b1;
            bus.high_z_c <= 1'b1;
        end else begin
            bus.duty_a   <= da_n;
            bus.duty_b   <= db_n;
            bus.duty_c   <= dc_n;
            bus.high_z_a <= hz_n[0];
            bus.high_z_b <= hz_n[1];
            bus.high_z_c <= hz_n[2];
        end
    end

endmodule
